// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared types and constants for the SHA-256 multi-block message controller.
package sha256_ctrl_pkg;

    localparam int unsigned BLK_W  = 512;
    localparam int unsigned HASH_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } ctrl_state_t;

    localparam logic [HASH_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_msg_ctrl_if.sv
// Block-in / digest-out handshake bundle of the SHA-256 message controller.
interface sha256_msg_ctrl_if;
    import sha256_ctrl_pkg::*;

    logic [BLK_W-1:0]  blk_data;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready;
    logic [HASH_W-1:0] digest;
    logic              digest_valid;
    logic              digest_ready;

    modport master (
        output blk_data, blk_valid, blk_last, digest_ready,
        input  blk_ready, digest, digest_valid
    );

    modport slave (
        input  blk_data, blk_valid, blk_last, digest_ready,
        output blk_ready, digest, digest_valid
    );

endinterface

// File: rtl/sha256_msg_ctrl_wdog.sv
// Clearable up-counter that flags expiry on the cycle it reaches LIMIT.
module sha256_ctrl_wdog #(
    parameter int unsigned LIMIT = 80
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Sequences an iterative SHA-256 core across the blocks of a padded message.
// Optional watchdog on the core strobe: define SHA_CTRL_TIMEOUT_EN.
module sha256_msg_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic              clk,
    input  logic              rst,
    sha256_msg_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic [HASH_W-1:0] core_H_in,
    output logic [BLK_W-1:0]  core_M,
    output logic              core_in_v,
    input  logic [HASH_W-1:0] core_H_out,
    input  logic              core_out_v,
    output logic              err
);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("sha256_msg_ctrl: TIMEOUT must be at least 2");
    end

    ctrl_state_t       state;
    logic [HASH_W-1:0] chain;
    logic              last_q;
    logic              wd_expire;

    assign bus.blk_ready = (state == IDLE) && !rst;
    assign bus.digest    = chain;
    assign core_H_in     = chain;

`ifdef SHA_CTRL_TIMEOUT_EN
    logic wd_hit;

    // Counts through START as well, so expiry lands TIMEOUT cycles after START entry.
    sha256_ctrl_wdog #(.LIMIT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state == IDLE) || (state == DONE)),
        .en     ((state == START) || (state == RUN)),
        .expire (wd_hit)
    );

    assign wd_expire = wd_hit && (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wd_expire && !core_out_v) begin
            err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            chain            <= SHA256_IV;
            core_M           <= '0;
            last_q           <= 1'b0;
            core_in_v        <= 1'b0;
            bus.digest_valid <= 1'b0;
            blk_cnt          <= '0;
        end else begin
            core_in_v <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.blk_valid) begin
                        core_M    <= bus.blk_data;
                        last_q    <= bus.blk_last;
                        core_in_v <= 1'b1;
                        state     <= START;
                    end
                end
                // core_out_v is stale here: the core has not restarted its rounds yet
                START: state <= RUN;
                RUN: begin
                    if (core_out_v) begin
                        chain   <= core_H_out;
                        blk_cnt <= blk_cnt + CNT_W'(1);
                        if (last_q) begin
                            bus.digest_valid <= 1'b1;
                            state            <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wd_expire) begin
                        chain <= SHA256_IV;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.digest_ready) begin
                        chain            <= SHA256_IV;
                        blk_cnt          <= '0;
                        bus.digest_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl paired with a behavioural 64-round SHA-256 core.
module tb_sha256_msg_ctrl;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 80;
    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] blk_cnt;
    logic [255:0]     core_H_in;
    logic [511:0]     core_M;
    logic             core_in_v;
    logic [255:0]     core_H_out;
    logic             core_out_v;
    logic             err;

    sha256_msg_ctrl_if bus ();

    sha256_msg_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .blk_cnt    (blk_cnt),
        .core_H_in  (core_H_in),
        .core_M     (core_M),
        .core_in_v  (core_in_v),
        .core_H_out (core_H_out),
        .core_out_v (core_out_v),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural core: loads on core_in_v, one round per cycle, strobes for one cycle at round 64.
    logic [31:0]  w [64];
    logic [31:0]  ra, rb, rc, rd, re, rf, rg, rh;
    logic [255:0] hin_q = '0;
    int unsigned  rnd = 65;
    logic         stale_inj = 1'b0;
    logic         mute = 1'b0;
    logic [255:0] stale_val = '0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign core_out_v = ((rnd == 64) && !mute) || stale_inj;
    assign core_H_out = stale_inj ? stale_val :
        {hin_q[255:224] + ra, hin_q[223:192] + rb, hin_q[191:160] + rc, hin_q[159:128] + rd,
         hin_q[127:96]  + re, hin_q[95:64]   + rf, hin_q[63:32]   + rg, hin_q[31:0]    + rh};

    always @(posedge clk) begin
        logic [31:0] t1, t2, s0, s1;
        if (core_in_v) begin
            for (int i = 0; i < 16; i++) w[i] = core_M[511 - 32*i -: 32];
            for (int i = 16; i < 64; i++) begin
                s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
                s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
                w[i] = w[i-16] + s0 + w[i-7] + s1;
            end
            hin_q <= core_H_in;
            {ra, rb, rc, rd, re, rf, rg, rh} <= core_H_in;
            rnd <= 0;
        end else if (rnd < 64) begin
            t1 = rh + (rotr(re, 6) ^ rotr(re, 11) ^ rotr(re, 25)) + ((re & rf) ^ (~re & rg)) + K[rnd] + w[rnd];
            t2 = (rotr(ra, 2) ^ rotr(ra, 13) ^ rotr(ra, 22)) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
            rh <= rg; rg <= rf; rf <= re; re <= rd + t1;
            rd <= rc; rc <= rb; rb <= ra; ra <= t1 + t2;
            rnd <= rnd + 1;
        end else if (rnd == 64) begin
            rnd <= 65;
        end
    end

    typedef struct {
        logic [255:0]     dig;
        logic [CNT_W-1:0] cnt;
        time              t_acc;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [511:0] d, input logic l, output time t_acc);
        int n = 0;
        bus.blk_data  = d;
        bus.blk_last  = l;
        bus.blk_valid = 1'b1;
        while (!bus.blk_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", {511'b0, bus.blk_ready}, 512'd1);
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.blk_valid = 1'b0;
    endtask

    task automatic get_digest(input int hold);
        exp_t e;
        int   n = 0;
        if (sb.size() == 0) begin
            chk("sb_empty", 512'd1, 512'd0);
            return;
        end
        e = sb.pop_front();
        while (!bus.digest_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dv_latency", 512'(($time - 1 - e.t_acc) / 10), 512'd66);
        chk("digest", 512'(bus.digest), 512'(e.dig));
        chk("blk_cnt", 512'(blk_cnt), 512'(e.cnt));
        for (int i = 0; i < hold; i++) begin
            bus.blk_valid = 1'b1;
            bus.blk_data  = {16{$urandom}};
            bus.blk_last  = 1'b1;
            @(posedge clk); #1;
            chk("bp_digest", 512'(bus.digest), 512'(e.dig));
            chk("bp_ready", {511'b0, bus.blk_ready}, 512'd0);
            chk("bp_start", {511'b0, core_in_v}, 512'd0);
            chk("bp_dvalid", {511'b0, bus.digest_valid}, 512'd1);
        end
        bus.blk_valid    = 1'b0;
        bus.digest_ready = 1'b1;
        @(posedge clk); #1;
        bus.digest_ready = 1'b0;
        chk("take_ready", {511'b0, bus.blk_ready}, 512'd1);
        chk("take_iv", 512'(core_H_in), 512'(IV));
        chk("take_cnt", 512'(blk_cnt), 512'd0);
        chk("take_dvalid", {511'b0, bus.digest_valid}, 512'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {511'b0, bus.blk_ready}, 512'd0);
        chk({tag, "_dvalid"}, {511'b0, bus.digest_valid}, 512'd0);
        chk({tag, "_in_v"}, {511'b0, core_in_v}, 512'd0);
        chk({tag, "_cnt"}, 512'(blk_cnt), 512'd0);
        chk({tag, "_err"}, {511'b0, err}, 512'd0);
        chk({tag, "_chain"}, 512'(core_H_in), 512'(IV));
        chk({tag, "_core_m"}, core_M, 512'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        time t0, t1;
        int  n;
        rst              = 1'b1;
        bus.blk_data     = '0;
        bus.blk_valid    = 1'b0;
        bus.blk_last     = 1'b0;
        bus.digest_ready = 1'b0;
        #2;
        check_reset_vals("rst");
        @(posedge clk); #1;
        chk("rst_ready_hi", {511'b0, bus.blk_ready}, 512'd0);
        rst = 1'b0;
        #1;
        chk("release_ready", {511'b0, bus.blk_ready}, 512'd1);

        // single-block "abc"
        send(ABC_BLK, 1'b1, t0);
        chk("start_pulse", {511'b0, core_in_v}, 512'd1);
        chk("start_chain", 512'(core_H_in), 512'(IV));
        chk("start_core_m", core_M, ABC_BLK);
        sb.push_back('{dig: ABC, cnt: CNT_W'(1), t_acc: t0});
        @(posedge clk); #1;
        chk("pulse_one_cycle", {511'b0, core_in_v}, 512'd0);
        get_digest(0);

        // two-block message with valid held high through the first block
        send(TWO_B1, 1'b0, t0);
        send(TWO_B2, 1'b1, t1);
        chk("blk_spacing", 512'((t1 - t0) / 10), 512'd67);
        sb.push_back('{dig: TWO, cnt: CNT_W'(2), t_acc: t1});
        get_digest(20);

        // stale strobe with a bogus result during START must be ignored
        send(ABC_BLK, 1'b1, t0);
        stale_val = {8{32'hdeadbeef}};
        stale_inj = 1'b1;
        @(posedge clk); #1;
        stale_inj = 1'b0;
        chk("stale_chain", 512'(core_H_in), 512'(IV));
        chk("stale_cnt", 512'(blk_cnt), 512'd0);
        chk("stale_dvalid", {511'b0, bus.digest_valid}, 512'd0);
        sb.push_back('{dig: ABC, cnt: CNT_W'(1), t_acc: t0});
        get_digest(0);

        // reset in RUN at round 30, core keeps running
        send(TWO_B1, 1'b0, t0);
        n = 0;
        while (rnd != 30 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_round30", 512'(rnd), 512'd30);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_release", {511'b0, bus.blk_ready}, 512'd1);
        repeat (50) begin
            @(posedge clk); #1;
        end
        chk("orphan_cnt", 512'(blk_cnt), 512'd0);
        chk("orphan_chain", 512'(core_H_in), 512'(IV));
        chk("orphan_dvalid", {511'b0, bus.digest_valid}, 512'd0);
        send(ABC_BLK, 1'b1, t0);
        sb.push_back('{dig: ABC, cnt: CNT_W'(1), t_acc: t0});
        get_digest(0);

`ifdef SHA_CTRL_TIMEOUT_EN
        mute = 1'b1;
        send(ABC_BLK, 1'b1, t0);
        repeat (TIMEOUT - 1) begin
            @(posedge clk); #1;
        end
        chk("wd_early", {511'b0, err}, 512'd0);
        @(posedge clk); #1;
        chk("wd_err", {511'b0, err}, 512'd1);
        chk("wd_ready", {511'b0, bus.blk_ready}, 512'd1);
        chk("wd_chain", 512'(core_H_in), 512'(IV));
        mute = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("wd_sticky", {511'b0, err}, 512'd1);
`else
        chk("err_tied", {511'b0, err}, 512'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
